// File: rtl/maquina_planta_if.sv
// Command/sensor bundle between the wash controller and the washing-machine plant.
// master: controller side (drives valve/agitate/spin, reads sensors and status).
// slave:  plant side (reads commands, drives cheio/tempo/secar, nivel, estado, erro).
interface maquina_planta_if #(
    parameter int W = 8
);
    logic         valvula_agua;
    logic         modo_agitar;
    logic         modo_girar;
    logic         cheio;
    logic         tempo;
    logic         secar;
    logic [W-1:0] nivel;
    logic [1:0]   estado;
    logic         erro;

    modport master (
        output valvula_agua, modo_agitar, modo_girar,
        input  cheio, tempo, secar, nivel, estado, erro
    );

    modport slave (
        input  valvula_agua, modo_agitar, modo_girar,
        output cheio, tempo, secar, nivel, estado, erro
    );
endinterface

// File: rtl/maquina_planta.sv
// Washing-machine plant model: water level, agitation timer and spin/drain cycle.
// Latency: one cycle, every output is registered and reflects the command sampled at that edge.
// Backpressure: none; commands are sampled every edge, and illegal combinations freeze state and set erro.
// Ports: clock, reset_n (async active-low), io_planta (slave: commands in, cheio/tempo/secar/nivel/estado/erro out).
module maquina_planta #(
    parameter int W         = 8,
    parameter int NIVEL_MAX = 15,
    parameter int TW        = 16,
    parameter int T_AGITAR  = 20,
    parameter int T_GIRAR   = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    maquina_planta_if.slave  io_planta
);
    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ENCHENDO      = 2'd1,
        AGITANDO      = 2'd2,
        CENTRIFUGANDO = 2'd3
    } estado_t;

    localparam logic [W-1:0] L_NIVEL_MAX = W'(NIVEL_MAX);
    localparam logic [TW:0]  L_T_AG_EXT  = (TW+1)'(T_AGITAR);
    localparam logic [TW:0]  L_T_GI_EXT  = (TW+1)'(T_GIRAR);

    estado_t       r_estado;
    logic [W-1:0]  r_nivel;
    logic [TW-1:0] r_cnt_ag;
    logic [TW-1:0] r_cnt_gi;
    logic          r_cheio;
    logic          r_tempo;
    logic          r_secar;
    logic          r_erro;

    estado_t       w_estado_nx;
    logic [W-1:0]  w_nivel_nx;
    logic [TW-1:0] w_cnt_ag_nx;
    logic [TW-1:0] w_cnt_gi_nx;
    logic          w_cheio_nx;
    logic          w_tempo_nx;
    logic          w_secar_nx;
    logic          w_erro_nx;
    logic          w_ilegal;
    logic [TW:0]   w_ag_inc;
    logic [TW:0]   w_gi_inc;

    // More than one actuator command at once is a protocol violation.
    assign w_ilegal = (io_planta.valvula_agua & io_planta.modo_agitar) |
                      (io_planta.valvula_agua & io_planta.modo_girar)  |
                      (io_planta.modo_agitar  & io_planta.modo_girar);

    // One extra bit so the increment never wraps before the saturation compare.
    assign w_ag_inc = {1'b0, r_cnt_ag} + (TW+1)'(1);
    assign w_gi_inc = {1'b0, r_cnt_gi} + (TW+1)'(1);

    // State register (mode plus the plant's physical state).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
            r_nivel  <= '0;
            r_cnt_ag <= '0;
            r_cnt_gi <= '0;
            r_cheio  <= 1'b0;
            r_tempo  <= 1'b0;
            r_secar  <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_estado <= w_estado_nx;
            r_nivel  <= w_nivel_nx;
            r_cnt_ag <= w_cnt_ag_nx;
            r_cnt_gi <= w_cnt_gi_nx;
            r_cheio  <= w_cheio_nx;
            r_tempo  <= w_tempo_nx;
            r_secar  <= w_secar_nx;
            r_erro   <= w_erro_nx;
        end
    end

    // Next mode: follows the single active command; an illegal edge holds the mode.
    always_comb begin
        w_estado_nx = r_estado;
        if (!w_ilegal) begin
            if (io_planta.valvula_agua)     w_estado_nx = ENCHENDO;
            else if (io_planta.modo_agitar) w_estado_nx = AGITANDO;
            else if (io_planta.modo_girar)  w_estado_nx = CENTRIFUGANDO;
            else                            w_estado_nx = OCIOSO;
        end
    end

    // Plant response for the mode entered at this edge.
    always_comb begin
        w_nivel_nx  = r_nivel;
        w_cnt_ag_nx = r_cnt_ag;
        w_cnt_gi_nx = r_cnt_gi;
        w_tempo_nx  = r_tempo;
        w_secar_nx  = r_secar;
        w_erro_nx   = r_erro;
        w_cheio_nx  = r_cheio;
        if (w_ilegal) begin
            w_erro_nx = 1'b1;
        end else begin
            case (w_estado_nx)
                OCIOSO: begin
                    w_cnt_ag_nx = '0;
                    w_cnt_gi_nx = '0;
                    w_tempo_nx  = 1'b0;
                    w_secar_nx  = 1'b0;
                end
                ENCHENDO: begin
                    if (r_nivel < L_NIVEL_MAX) w_nivel_nx = r_nivel + W'(1);
                    else                       w_nivel_nx = L_NIVEL_MAX;
                    w_cnt_ag_nx = '0;
                    w_cnt_gi_nx = '0;
                    w_tempo_nx  = 1'b0;
                end
                AGITANDO: begin
                    // secar is pre-armed here so the controller sees it set on entering spin.
                    if (w_ag_inc >= L_T_AG_EXT) begin
                        w_cnt_ag_nx = L_T_AG_EXT[TW-1:0];
                        w_tempo_nx  = 1'b1;
                        w_secar_nx  = 1'b1;
                    end else begin
                        w_cnt_ag_nx = w_ag_inc[TW-1:0];
                    end
                    w_cnt_gi_nx = '0;
                    if (r_nivel == '0) w_erro_nx = 1'b1;
                end
                default: begin
                    if (r_nivel != '0) w_nivel_nx = r_nivel - W'(1);
                    if (w_gi_inc >= L_T_GI_EXT) w_cnt_gi_nx = L_T_GI_EXT[TW-1:0];
                    else                        w_cnt_gi_nx = w_gi_inc[TW-1:0];
                    w_cnt_ag_nx = '0;
                    w_tempo_nx  = 1'b0;
                    // Spin ends only once both the minimum time has passed and the tank is empty.
                    w_secar_nx  = !((w_gi_inc >= L_T_GI_EXT) && (w_nivel_nx == '0));
                end
            endcase
            w_cheio_nx = (w_nivel_nx == L_NIVEL_MAX);
        end
    end

    assign io_planta.nivel  = r_nivel;
    assign io_planta.estado = r_estado;
    assign io_planta.cheio  = r_cheio;
    assign io_planta.tempo  = r_tempo;
    assign io_planta.secar  = r_secar;
    assign io_planta.erro   = r_erro;
endmodule

// File: tb/tb_maquina_planta.sv
module tb_maquina_planta;
    localparam int NMAX = 15;
    localparam int TAG  = 20;
    localparam int TGI  = 10;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    maquina_planta_if #(.W(8)) u_if ();
    maquina_planta_if #(.W(8)) u_if2 ();

    maquina_planta #(.W(8), .NIVEL_MAX(NMAX), .TW(16), .T_AGITAR(TAG), .T_GIRAR(TGI)) u_dut (
        .clock(clock), .reset_n(reset_n), .io_planta(u_if.slave)
    );
    maquina_planta #(.W(8), .NIVEL_MAX(5), .TW(16), .T_AGITAR(TAG), .T_GIRAR(TGI)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .io_planta(u_if2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model of the main plant, kept as plain integers.
    int m_nivel, m_cag, m_cgi, m_estado;
    bit m_cheio, m_tempo, m_secar, m_erro;

    task automatic model_reset();
        m_nivel = 0; m_cag = 0; m_cgi = 0; m_estado = 0;
        m_cheio = 0; m_tempo = 0; m_secar = 0; m_erro = 0;
    endtask

    task automatic model_step(input bit va, input bit ag, input bit gi);
        int n;
        n = int'(va) + int'(ag) + int'(gi);
        if (n > 1) begin
            m_erro = 1;
        end else begin
            if (n == 0) begin
                m_estado = 0; m_cag = 0; m_cgi = 0; m_tempo = 0; m_secar = 0;
            end else if (va) begin
                m_estado = 1;
                m_nivel  = (m_nivel + 1 > NMAX) ? NMAX : m_nivel + 1;
                m_cag = 0; m_cgi = 0; m_tempo = 0;
            end else if (ag) begin
                m_estado = 2;
                if (m_nivel == 0) m_erro = 1;
                if (m_cag + 1 >= TAG) begin m_tempo = 1; m_secar = 1; end
                m_cag = (m_cag + 1 > TAG) ? TAG : m_cag + 1;
                m_cgi = 0;
            end else begin
                m_estado = 3;
                m_nivel  = (m_nivel > 0) ? m_nivel - 1 : 0;
                m_secar  = !((m_cgi + 1 >= TGI) && (m_nivel == 0));
                m_cgi    = (m_cgi + 1 > TGI) ? TGI : m_cgi + 1;
                m_cag = 0; m_tempo = 0;
            end
            m_cheio = (m_nivel == NMAX);
        end
    endtask

    // Drive one command set, take one edge, advance the model, settle 1 ns past the edge.
    task automatic tick(input bit va, input bit ag, input bit gi);
        u_if.valvula_agua = va;
        u_if.modo_agitar  = ag;
        u_if.modo_girar   = gi;
        @(posedge clock);
        model_step(va, ag, gi);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got nivel=%0d estado=%0d cheio=%b tempo=%b secar=%b erro=%b, want all 0",
                     u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro);
        end
        n_checks++;
        if (u_if2.nivel !== 8'd0 || u_if2.secar !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state2: got nivel=%0d secar=%b, want 0 0", u_if2.nivel, u_if2.secar);
        end
        #6;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 17; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if (u_if.nivel !== 8'((i > NMAX) ? NMAX : i) || u_if.cheio !== (i >= NMAX) || u_if.estado !== 2'd1) begin
                n_fail++;
                $display("FAIL fill edge %0d: got nivel=%0d cheio=%b estado=%0d, want nivel=%0d cheio=%b estado=1",
                         i, u_if.nivel, u_if.cheio, u_if.estado, (i > NMAX) ? NMAX : i, i >= NMAX);
            end
        end
    endtask

    task automatic test_agitate();
        for (int i = 1; i <= TAG; i++) begin
            tick(0, 1, 0);
            n_checks++;
            if (u_if.tempo !== (i >= TAG) || u_if.secar !== (i >= TAG) || u_if.nivel !== 8'd15 || u_if.erro !== 1'b0) begin
                n_fail++;
                $display("FAIL agitate edge %0d: got tempo=%b secar=%b nivel=%0d erro=%b, want tempo=%b secar=%b nivel=15 erro=0",
                         i, u_if.tempo, u_if.secar, u_if.nivel, u_if.erro, i >= TAG, i >= TAG);
            end
        end
    endtask

    task automatic test_spin();
        for (int i = 1; i <= 15; i++) begin
            tick(0, 0, 1);
            n_checks++;
            if (u_if.nivel !== 8'(15 - i) || u_if.secar !== (i < 15) || u_if.tempo !== 1'b0 ||
                u_if.cheio !== 1'b0 || u_if.estado !== 2'd3) begin
                n_fail++;
                $display("FAIL spin edge %0d: got nivel=%0d secar=%b tempo=%b cheio=%b estado=%0d, want nivel=%0d secar=%b tempo=0 cheio=0 estado=3",
                         i, u_if.nivel, u_if.secar, u_if.tempo, u_if.cheio, u_if.estado, 15 - i, i < 15);
            end
        end
        tick(0, 0, 0);
        n_checks++;
        if (u_if.estado !== 2'd0 || u_if.secar !== 1'b0 || u_if.nivel !== 8'd0) begin
            n_fail++;
            $display("FAIL spin_idle: got estado=%0d secar=%b nivel=%0d, want 0 0 0", u_if.estado, u_if.secar, u_if.nivel);
        end
    endtask

    task automatic test_protocol_error();
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        tick(1, 0, 1);
        n_checks++;
        if (u_if.erro !== 1'b1 || u_if.nivel !== 8'd3 || u_if.estado !== 2'd1) begin
            n_fail++;
            $display("FAIL illegal_edge: got erro=%b nivel=%0d estado=%0d, want 1 3 1", u_if.erro, u_if.nivel, u_if.estado);
        end
        tick(0, 0, 0);
        n_checks++;
        if (u_if.erro !== 1'b1 || u_if.estado !== 2'd0) begin
            n_fail++;
            $display("FAIL erro_sticky: got erro=%b estado=%0d, want 1 0", u_if.erro, u_if.estado);
        end
        tick(1, 0, 0);
        n_checks++;
        if (u_if.erro !== 1'b1 || u_if.nivel !== 8'd4) begin
            n_fail++;
            $display("FAIL erro_sticky_fill: got erro=%b nivel=%0d, want 1 4", u_if.erro, u_if.nivel);
        end
        do_reset();
        n_checks++;
        if (u_if.erro !== 1'b0 || u_if.nivel !== 8'd0) begin
            n_fail++;
            $display("FAIL erro_reset: got erro=%b nivel=%0d, want 0 0", u_if.erro, u_if.nivel);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NMAX; i++) tick(1, 0, 0);
        for (int i = 0; i < TAG; i++)  tick(0, 1, 0);
        for (int i = 0; i < 8; i++)    tick(0, 0, 1);
        n_checks++;
        if (u_if.nivel !== 8'd7 || u_if.secar !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_setup: got nivel=%0d secar=%b, want 7 1", u_if.nivel, u_if.secar);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro} !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset: got nivel=%0d estado=%0d cheio=%b tempo=%b secar=%b erro=%b, want all 0",
                     u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_spin_small_tank();
        u_if2.valvula_agua = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        n_checks++;
        if (u_if2.nivel !== 8'd5 || u_if2.cheio !== 1'b1) begin
            n_fail++;
            $display("FAIL small_fill: got nivel=%0d cheio=%b, want 5 1", u_if2.nivel, u_if2.cheio);
        end
        u_if2.valvula_agua = 1'b0;
        u_if2.modo_girar   = 1'b1;
        for (int i = 1; i <= TGI; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (u_if2.secar !== (i < TGI) || u_if2.nivel !== 8'((i < 5) ? 5 - i : 0)) begin
                n_fail++;
                $display("FAIL small_spin edge %0d: got secar=%b nivel=%0d, want secar=%b nivel=%0d",
                         i, u_if2.secar, u_if2.nivel, i < TGI, (i < 5) ? 5 - i : 0);
            end
        end
        u_if2.modo_girar = 1'b0;
    endtask

    task automatic test_random();
        int remaining = 400;
        while (remaining > 0) begin
            int sel = $urandom_range(0, 3);
            int len = $urandom_range(1, 25);
            bit bad = ($urandom_range(0, 24) == 0);
            for (int k = 0; k < len && remaining > 0; k++) begin
                remaining--;
                if (bad) tick(1, sel[0], 1);
                else     tick(sel == 1, sel == 2, sel == 3);
                n_checks++;
                if ({u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro} !==
                    {8'(m_nivel), 2'(m_estado), m_cheio, m_tempo, m_secar, m_erro}) begin
                    n_fail++;
                    $display("FAIL random cycle %0d: got nivel=%0d estado=%0d cheio=%b tempo=%b secar=%b erro=%b, want %0d %0d %b %b %b %b",
                             remaining, u_if.nivel, u_if.estado, u_if.cheio, u_if.tempo, u_if.secar, u_if.erro,
                             m_nivel, m_estado, m_cheio, m_tempo, m_secar, m_erro);
                end
            end
        end
        do_reset();
    endtask

    // Behavioural wash controller closing the loop: fill until cheio, agitate until tempo, spin until !secar.
    task automatic test_closed_loop();
        int fase = 1;
        int cyc  = 0;
        int cnt_fill = 0, cnt_ag = 0, cnt_gi = 0;
        while (fase != 0 && cyc < 200) begin
            cyc++;
            tick(fase == 1, fase == 2, fase == 3);
            if (fase == 1) begin cnt_fill++; if (u_if.cheio) fase = 2; end
            else if (fase == 2) begin cnt_ag++; if (u_if.tempo) fase = 3; end
            else begin cnt_gi++; if (!u_if.secar) fase = 0; end
        end
        tick(0, 0, 0);
        n_checks++;
        if (fase != 0) begin
            n_fail++;
            $display("FAIL closed_loop_timeout: got fase=%0d after %0d cycles, want 0", fase, cyc);
        end
        n_checks++;
        if (cnt_fill != 15 || cnt_ag != TAG || cnt_gi != 15) begin
            n_fail++;
            $display("FAIL closed_loop_phases: got fill=%0d agitate=%0d spin=%0d, want 15 20 15", cnt_fill, cnt_ag, cnt_gi);
        end
        n_checks++;
        if (u_if.estado !== 2'd0 || u_if.nivel !== 8'd0 || u_if.erro !== 1'b0) begin
            n_fail++;
            $display("FAIL closed_loop_end: got estado=%0d nivel=%0d erro=%b, want 0 0 0", u_if.estado, u_if.nivel, u_if.erro);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        u_if.valvula_agua = 1'b0;  u_if.modo_agitar = 1'b0;  u_if.modo_girar = 1'b0;
        u_if2.valvula_agua = 1'b0; u_if2.modo_agitar = 1'b0; u_if2.modo_girar = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_agitate();
        test_spin();
        test_protocol_error();
        test_async_reset();
        test_spin_small_tank();
        test_random();
        test_closed_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/maquina_planta.md
Name: maquina_planta

Overview:
- Behavioural and synthesizable plant model of the washing machine; it responds to the wash controller's actuator commands.
- Consumes valvula_agua, modo_agitar and modo_girar, and produces the sensor signals the controller consumes: cheio, tempo and secar.
- Models the water level, the agitation timer and the spin/drain cycle.
- Used on-board for closed-loop demo and in benches as the controller's counterpart.

Parameters:
- W, 8, width of water-level counter.
- NIVEL_MAX, 15, level at which the tank counts as full; must satisfy 1 <= NIVEL_MAX <= 2^W-1.
- TW, 16, width of agitation/spin timers.
- T_AGITAR, 20, agitation cycles before tempo asserts (>=1).
- T_GIRAR, 10, minimum spin cycles before secar may drop (>=1).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- valvula_agua  in  1  fill valve command.
- modo_agitar  in  1  agitate command.
- modo_girar  in  1  spin/drain command.
- cheio  out  1  tank full.
- tempo  out  1  agitation time elapsed.
- secar  out  1  spin/drain in progress (1 = keep spinning).
- nivel  out  W  current water level.
- estado  out  2  plant mode: 0 OCIOSO, 1 ENCHENDO, 2 AGITANDO, 3 CENTRIFUGANDO.
- erro  out  1  sticky command-protocol violation.

Behaviour:
- Reset (async, reset_n=0): nivel=0, cnt_ag=0, cnt_gi=0, cheio=0, tempo=0, secar=0, estado=OCIOSO, erro=0.
- All outputs are registered. Inputs are sampled at posedge. Each response appears at the same edge that samples the command (one-cycle latency from input change).
- Command decode per edge:
  - none high -> OCIOSO.
  - exactly one high -> the matching mode.
  - more than one high -> illegal.
- Illegal edge:
  - erro<=1; erro stays 1 until reset.
  - nivel, counters, cheio, tempo, secar and estado all hold.
- OCIOSO edge: cnt_ag<=0, cnt_gi<=0, tempo<=0, secar<=0; nivel holds.
- ENCHENDO edge:
  - nivel<=min(nivel+1, NIVEL_MAX), saturating with no wrap.
  - cnt_ag<=0, cnt_gi<=0, tempo<=0.
- AGITANDO edge:
  - cnt_ag<=min(cnt_ag+1, T_AGITAR).
  - When cnt_ag+1 >= T_AGITAR: tempo<=1 and secar<=1 (pre-arms spin so the controller sees secar=1 on entering spin).
  - cnt_gi<=0.
  - If nivel==0 at this edge: erro<=1 (agitating an empty tank); counting still proceeds.
- CENTRIFUGANDO edge:
  - nivel<=max(nivel-1, 0) (drain).
  - cnt_gi<=min(cnt_gi+1, T_GIRAR).
  - cnt_ag<=0, tempo<=0.
  - secar<=0 iff (cnt_gi+1 >= T_GIRAR) and (next nivel == 0); otherwise secar<=1.
- cheio<=(next nivel == NIVEL_MAX) on every non-illegal edge. cheio therefore rises on the edge nivel reaches NIVEL_MAX and falls on the first drain edge.
- Direct mode switches with no idle gap (AGITANDO -> CENTRIFUGANDO) are legal; there is no settle cycle.
- Leaving AGITANDO clears cnt_ag and tempo at the first non-agitate edge. secar is preserved into CENTRIFUGANDO.
- If reset_n deasserts mid-cycle, the plant restarts from an empty tank; no state survives.

Test Plan:
- Reset: assert reset_n=0 while nivel=7, secar=1 -> all outputs 0 immediately (async), estado=0.
- Fill: valvula_agua=1 for 17 edges -> nivel steps 1..15; cheio=1 from edge 15; nivel stays 15 at edges 16-17.
- Agitate: from nivel=15, modo_agitar=1 -> tempo=0 through edge 19; tempo=1 and secar=1 at edge 20. Then switch to modo_girar -> tempo=0 at the next edge, secar still 1.
- Spin: nivel=15, modo_girar=1 -> cheio=0 at edge 1, nivel decrements each edge. secar=1 until edge 15, where nivel=0 and secar=0 (drain dominates T_GIRAR=10). With NIVEL_MAX=5 instead, secar drops at edge 10.
- Protocol error: valvula_agua=1 and modo_girar=1 on one edge -> erro=1, nivel and estado unchanged. erro remains 1 after the commands return legal, until reset.
- Closed loop with the wash controller: inicio pulse -> fill 15, agitate 20, spin 15 -> controller back in idle and plant in OCIOSO with nivel=0, erro=0.
